// File: rtl/pi1_rr_arbiter_if.sv
// pi1 bus bundle between MASTERCOUNT masters, the round-robin arbiter and one slave.
// Directions are named from the arbiter's side; `slave` is the arbiter view, `master` the environment view.
interface pi1_rr_arbiter_if #(
  parameter int ARCHBITSZ   = 32,
  parameter int MASTERCOUNT = 4
);
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8);
  localparam int SELBITSZ  = ARCHBITSZ/8;

  logic [MASTERCOUNT-1:0][1:0]           m_pi1_op_i;
  logic [MASTERCOUNT-1:0][ADDRBITSZ-1:0] m_pi1_addr_i;
  logic [MASTERCOUNT-1:0][ARCHBITSZ-1:0] m_pi1_data_i;
  logic [MASTERCOUNT-1:0][SELBITSZ-1:0]  m_pi1_sel_i;
  logic [ARCHBITSZ-1:0]                  m_pi1_data_o;
  logic [MASTERCOUNT-1:0]                m_pi1_rdy_o;
  logic [1:0]                            s_pi1_op_o;
  logic [ADDRBITSZ-1:0]                  s_pi1_addr_o;
  logic [ARCHBITSZ-1:0]                  s_pi1_data_o;
  logic [SELBITSZ-1:0]                   s_pi1_sel_o;
  logic [ARCHBITSZ-1:0]                  s_pi1_data_i;
  logic                                  s_pi1_rdy_i;

  modport slave (
    input  m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i, s_pi1_data_i, s_pi1_rdy_i,
    output m_pi1_data_o, m_pi1_rdy_o, s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o
  );

  modport master (
    output m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i, s_pi1_data_i, s_pi1_rdy_i,
    input  m_pi1_data_o, m_pi1_rdy_o, s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o
  );
endinterface

// File: rtl/pi1_rr_arbiter.sv
// Round-robin arbiter: one pi1 slave shared by MASTERCOUNT masters, whole transactions per grant.
// Optional PI1_ARB_BURST_EN: up to BURSTLEN back-to-back transactions per grant.
module pi1_rr_arbiter #(
  parameter  int ARCHBITSZ   = 32,
  parameter  int MASTERCOUNT = 4,
  parameter  int BURSTLEN    = 4,
  localparam int GNTBITSZ    = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pi1_rr_arbiter_if.slave      bus,
  output logic [GNTBITSZ-1:0]  gnt_o
);

  if (ARCHBITSZ < 8 || (ARCHBITSZ % 8) != 0 || MASTERCOUNT < 1 || BURSTLEN < 1) begin : g_cfg_chk
    $error("pi1_rr_arbiter: illegal parameter set");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e              state_q, state_d;
  logic [GNTBITSZ-1:0] gnt_q, gnt_d;
  logic [GNTBITSZ-1:0] ptr_q, ptr_d;
  logic [GNTBITSZ-1:0] gnt_inc;
  logic [GNTBITSZ-1:0] scan_idx;
  logic                scan_hit;
  logic [1:0]          cur_op;

`ifdef PI1_ARB_BURST_EN
  localparam int CNTBITSZ = (BURSTLEN > 1) ? $clog2(BURSTLEN) : 1;
  logic [CNTBITSZ-1:0] cnt_q, cnt_d;
`endif

  function automatic logic [GNTBITSZ-1:0] wrap_idx(input int v);
    return GNTBITSZ'((v >= MASTERCOUNT) ? v - MASTERCOUNT : v);
  endfunction

  assign cur_op  = bus.m_pi1_op_i[gnt_q];
  assign gnt_inc = (gnt_q == GNTBITSZ'(MASTERCOUNT-1)) ? '0 : gnt_q + 1'b1;
  assign gnt_o   = gnt_q;

  // Walk from the farthest offset down so the requester closest to ptr wins.
  always_comb begin
    scan_hit = 1'b0;
    scan_idx = '0;
    for (int i = MASTERCOUNT-1; i >= 0; i--) begin
      if (bus.m_pi1_op_i[wrap_idx(int'(ptr_q) + i)] != 2'd0) begin
        scan_hit = 1'b1;
        scan_idx = wrap_idx(int'(ptr_q) + i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
`ifdef PI1_ARB_BURST_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
`ifdef PI1_ARB_BURST_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
`ifdef PI1_ARB_BURST_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (scan_hit) begin
          state_d = S_ISSUE;
          gnt_d   = scan_idx;
`ifdef PI1_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end
      end
      S_ISSUE: begin
        // A master that withdraws before acceptance forfeits its turn.
        if (cur_op == 2'd0) begin
          state_d = S_IDLE;
          ptr_d   = gnt_inc;
        end else if (bus.s_pi1_rdy_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.s_pi1_rdy_i) begin
`ifdef PI1_ARB_BURST_EN
          if (cur_op != 2'd0 && cnt_q < CNTBITSZ'(BURSTLEN-1)) begin
            state_d = S_ISSUE;
            cnt_d   = cnt_q + 1'b1;
          end else begin
            state_d = S_IDLE;
            ptr_d   = gnt_inc;
          end
`else
          state_d = S_IDLE;
          ptr_d   = gnt_inc;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.s_pi1_op_o   = (state_q == S_ISSUE) ? cur_op : 2'd0;
    bus.s_pi1_addr_o = bus.m_pi1_addr_i[gnt_q];
    bus.s_pi1_data_o = bus.m_pi1_data_i[gnt_q];
    bus.s_pi1_sel_o  = bus.m_pi1_sel_i[gnt_q];
    bus.m_pi1_data_o = bus.s_pi1_data_i;
    bus.m_pi1_rdy_o  = '0;
    if (state_q != S_IDLE) bus.m_pi1_rdy_o[gnt_q] = bus.s_pi1_rdy_i;
  end

endmodule

// File: tb/tb_pi1_rr_arbiter.sv
// Bench for pi1_rr_arbiter: transaction-level model compared every cycle plus directed literal checks.
module tb_pi1_rr_arbiter;
  localparam int AW = 32;
  localparam int MC = 4;
  localparam int BL = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;

  always #5 clk = ~clk;

  pi1_rr_arbiter_if #(.ARCHBITSZ(AW), .MASTERCOUNT(MC)) bus();

  pi1_rr_arbiter #(.ARCHBITSZ(AW), .MASTERCOUNT(MC), .BURSTLEN(BL)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .gnt_o (gnt)
  );

  int checks = 0;
  int errors = 0;

  // Model: owner of the slave (-1 = nobody), whether its op was accepted, rotation pointer.
  int own, ptr, cnt, mgnt;
  bit acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int first_req();
    for (int i = 0; i < MC; i++)
      if (bus.m_pi1_op_i[(ptr + i) % MC] != 2'd0) return (ptr + i) % MC;
    return -1;
  endfunction

  task automatic model_update();
    if (rst) begin
      own = -1; acc = 0; ptr = 0; cnt = 0; mgnt = 0;
    end else if (own < 0) begin
      int g;
      g = first_req();
      if (g >= 0) begin own = g; mgnt = g; acc = 0; cnt = 0; end
    end else if (!acc) begin
      if (bus.m_pi1_op_i[own] == 2'd0) begin ptr = (own + 1) % MC; own = -1; end
      else if (bus.s_pi1_rdy_i) acc = 1;
    end else if (bus.s_pi1_rdy_i) begin
`ifdef PI1_ARB_BURST_EN
      if (bus.m_pi1_op_i[own] != 2'd0 && cnt < BL-1) begin acc = 0; cnt++; end
      else begin ptr = (own + 1) % MC; own = -1; end
`else
      ptr = (own + 1) % MC; own = -1;
`endif
    end
  endtask

  task automatic model_compare();
    logic [1:0]    esop;
    logic [MC-1:0] erdy;
    esop = (own >= 0 && !acc) ? bus.m_pi1_op_i[own] : 2'd0;
    erdy = '0;
    if (own >= 0 && bus.s_pi1_rdy_i) erdy[own] = 1'b1;
    chk("model s_op", bus.s_pi1_op_o, esop);
    chk("model m_rdy", bus.m_pi1_rdy_o, erdy);
    chk("model gnt", gnt, mgnt);
    chk("model m_data", bus.m_pi1_data_o, bus.s_pi1_data_i);
    if (esop != 2'd0) begin
      chk("model s_addr", bus.s_pi1_addr_o, bus.m_pi1_addr_i[own]);
      chk("model s_data", bus.s_pi1_data_o, bus.m_pi1_data_i[own]);
      chk("model s_sel", bus.s_pi1_sel_o, bus.m_pi1_sel_i[own]);
    end
  endtask

  // Inputs change at posedge+1; outputs compared at negedge; model advances at posedge.
  task automatic step();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic all_ops(input logic [1:0] op);
    for (int k = 0; k < MC; k++) bus.m_pi1_op_i[k] = op;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    all_ops(2'd0);
    bus.s_pi1_rdy_i = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  int gq[$];
  int exp_rr[6]   = '{0, 1, 2, 3, 0, 1};
`ifdef PI1_ARB_BURST_EN
  int exp_pair[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
  int exp_pair[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
  int repeats;

  initial begin
    rst = 1'b1;
    bus.s_pi1_rdy_i  = 1'b1;
    bus.s_pi1_data_i = 32'h0;
    for (int k = 0; k < MC; k++) begin
      bus.m_pi1_op_i[k]   = 2'd2;
      bus.m_pi1_addr_i[k] = 30'h100 + 30'(k);
      bus.m_pi1_data_i[k] = 32'hA000_0000 | 32'(k);
      bus.m_pi1_sel_i[k]  = 4'(1 << k);
    end
    @(posedge clk);
    model_update();
    #1;

    // Reset held with everybody requesting RD, then the first cycle after release.
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("reset s_op", bus.s_pi1_op_o, 2'd0);
      chk("reset m_rdy", bus.m_pi1_rdy_o, 4'b0000);
      chk("reset gnt", gnt, 2'd0);
      step();
    end
    rst = 1'b0;
    #1;
    chk("post-reset s_op", bus.s_pi1_op_o, 2'd0);
    chk("post-reset m_rdy", bus.m_pi1_rdy_o, 4'b0000);
    chk("post-reset gnt", gnt, 2'd0);
    step();
    do_reset();

    // Single master write.
    bus.m_pi1_op_i[1]   = 2'd1;
    bus.m_pi1_addr_i[1] = 30'h40;
    bus.m_pi1_data_i[1] = 32'hDEAD_BEEF;
    bus.m_pi1_sel_i[1]  = 4'hF;
    #1;
    chk("single N s_op", bus.s_pi1_op_o, 2'd0);
    step();
    #1;
    chk("single N+1 s_op", bus.s_pi1_op_o, 2'd1);
    chk("single N+1 s_addr", bus.s_pi1_addr_o, 30'h40);
    chk("single N+1 s_data", bus.s_pi1_data_o, 32'hDEAD_BEEF);
    chk("single N+1 s_sel", bus.s_pi1_sel_o, 4'hF);
    chk("single N+1 m_rdy", bus.m_pi1_rdy_o, 4'b0010);
    chk("single N+1 gnt", gnt, 2'd1);
    step();
    bus.m_pi1_op_i[1] = 2'd0;
    #1;
    chk("single N+2 s_op", bus.s_pi1_op_o, 2'd0);
    chk("single N+2 m_rdy", bus.m_pi1_rdy_o, 4'b0010);
    step();
    #1;
    chk("single N+3 m_rdy", bus.m_pi1_rdy_o, 4'b0000);
    step();
    do_reset();

    // Round robin with every master requesting continuously.
    all_ops(2'd2);
    gq.delete();
    for (int i = 0; i < 20; i++) begin
      bus.s_pi1_data_i = $urandom;
      #1;
      if (bus.s_pi1_op_o != 2'd0) gq.push_back(int'(gnt));
      step();
    end
    chk("rr grant count>=6", gq.size() >= 6, 1'b1);
    for (int i = 0; i < 6 && i < gq.size(); i++)
      chk($sformatf("rr grant[%0d]", i), gq[i], exp_rr[i]);
    repeats = 0;
    for (int i = 1; i < gq.size(); i++) if (gq[i] == gq[i-1]) repeats++;
    chk("rr consecutive repeats", repeats, 0);
    do_reset();

    // Slave stall after m2's read is accepted; m0 raises a request during the stall.
    bus.m_pi1_op_i[2]   = 2'd2;
    bus.m_pi1_addr_i[2] = 30'h80;
    #1;
    chk("stall idle s_op", bus.s_pi1_op_o, 2'd0);
    step();
    #1;
    chk("stall issue gnt", gnt, 2'd2);
    chk("stall issue s_op", bus.s_pi1_op_o, 2'd2);
    chk("stall issue m_rdy", bus.m_pi1_rdy_o, 4'b0100);
    step();
    bus.m_pi1_op_i[2] = 2'd0;
    bus.s_pi1_rdy_i   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) bus.m_pi1_op_i[0] = 2'd2;
      #1;
      chk("stall m_rdy", bus.m_pi1_rdy_o, 4'b0000);
      chk("stall s_op", bus.s_pi1_op_o, 2'd0);
      step();
    end
    bus.s_pi1_rdy_i  = 1'b1;
    bus.s_pi1_data_i = 32'h1234_5678;
    #1;
    chk("stall done m_data", bus.m_pi1_data_o, 32'h1234_5678);
    chk("stall done m_rdy", bus.m_pi1_rdy_o, 4'b0100);
    step();
    #1;
    chk("stall m0 waits s_op", bus.s_pi1_op_o, 2'd0);
    step();
    #1;
    chk("stall m0 gnt", gnt, 2'd0);
    chk("stall m0 m_rdy", bus.m_pi1_rdy_o, 4'b0001);
    step();
    bus.m_pi1_op_i[0] = 2'd0;
    step();
    do_reset();

    // Withdrawn request: pointer wraps past m3 so the next scan starts at 0.
    bus.s_pi1_rdy_i   = 1'b0;
    bus.m_pi1_op_i[3] = 2'd2;
    step();
    #1;
    chk("withdraw gnt", gnt, 2'd3);
    chk("withdraw m_rdy", bus.m_pi1_rdy_o, 4'b0000);
    step();
    bus.m_pi1_op_i[3] = 2'd0;
    #1;
    chk("withdraw dropped s_op", bus.s_pi1_op_o, 2'd0);
    step();
    bus.m_pi1_op_i[0] = 2'd2;
    bus.m_pi1_op_i[3] = 2'd2;
    #1;
    chk("withdraw idle s_op", bus.s_pi1_op_o, 2'd0);
    step();
    bus.s_pi1_rdy_i = 1'b1;
    #1;
    chk("withdraw next gnt", gnt, 2'd0);
    chk("withdraw next m_rdy", bus.m_pi1_rdy_o, 4'b0001);
    step();
    all_ops(2'd0);
    step();
    step();

    // Reset while waiting on the slave.
    bus.m_pi1_op_i[1] = 2'd2;
    step();
    step();
    bus.m_pi1_op_i[1] = 2'd0;
    bus.s_pi1_rdy_i   = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.s_pi1_rdy_i = 1'b1;
    #1;
    chk("midreset m_rdy", bus.m_pi1_rdy_o, 4'b0000);
    chk("midreset gnt", gnt, 2'd0);
    step();
    do_reset();

    // Two masters requesting continuously: burst build groups them, default alternates.
    bus.m_pi1_op_i[0] = 2'd2;
    bus.m_pi1_op_i[1] = 2'd2;
    gq.delete();
    for (int i = 0; i < 30; i++) begin
      #1;
      if (bus.s_pi1_op_o != 2'd0) gq.push_back(int'(gnt));
      step();
    end
    chk("pair grant count>=8", gq.size() >= 8, 1'b1);
    for (int i = 0; i < 8 && i < gq.size(); i++)
      chk($sformatf("pair grant[%0d]", i), gq[i], exp_pair[i]);
    all_ops(2'd0);
    step();
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
